// File: rtl/vram_painter_if.sv
// Bus bundle between the painter and its timing generator / VRAM: coordinates in, read request and pixel out.
interface vram_painter_if #(
  parameter int PIX_PER_WORD = 6,
  parameter int ADDR_W       = 17
);
  logic [9:0]                  horzCoord;
  logic [9:0]                  vertCoord;
  logic [8*PIX_PER_WORD-1:0]   vram_rdata;
  logic                        rd_en;
  logic [ADDR_W-1:0]           a_vga;
  logic                        pixel;
  logic [23:0]                 colors;
  logic                        frame_done;
  logic [1:0]                  state_dbg;

  // rd_en/a_vga is a one-cycle read strobe with no back-pressure: the memory
  // must present vram_rdata exactly one clk after the cycle rd_en is high.
  modport master (
    output horzCoord, vertCoord, vram_rdata,
    input  rd_en, a_vga, pixel, colors, frame_done, state_dbg
  );
  modport slave (
    input  horzCoord, vertCoord, vram_rdata,
    output rd_en, a_vga, pixel, colors, frame_done, state_dbg
  );
endinterface

// File: rtl/vram_painter.sv
// Streams packed 8-bit VRAM pixels into a VGA image window with a fixed 2-clk latency.
// Optional one-pixel white border around the window: define VRAM_PAINTER_BORDER_EN.
module vram_painter #(
  parameter int          H_START      = 192,
  parameter int          V_START      = 112,
  parameter int          IMG_W        = 256,
  parameter int          IMG_H        = 256,
  parameter int          PIX_PER_WORD = 6,
  parameter int          ADDR_W       = 17,
  parameter logic [23:0] BG_COLOR     = 24'h000000
) (
  input logic           clk,
  input logic           rst,
  vram_painter_if.slave bus
);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int CNT_W  = $clog2(NPIX + 1);
  localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int DW     = 8 * PIX_PER_WORD;

  localparam logic [11:0] H_LO = 12'(H_START);
  localparam logic [11:0] H_HI = 12'(H_START + IMG_W);
  localparam logic [11:0] V_LO = 12'(V_START);
  localparam logic [11:0] V_HI = 12'(V_START + IMG_H);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q, state_d, eff_state;
  logic                armed_q, armed_d, armed_eff;
  logic [LANE_W-1:0]   lane_q, lane_d, lane_cur;
  logic [ADDR_W-1:0]   word_q, word_d, word_cur;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_cur;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   a_vga_q, a_vga_d;
  logic                s1_pix_q, s1_pix_d, s1_last_q, s1_last_d;
  logic [LANE_W-1:0]   s1_lane_q, s1_lane_d, s2_lane_q, s2_lane_d;
  logic                s2_pix_q, s2_pix_d, s2_last_q, s2_last_d;
  logic                s2_fresh_q, s2_fresh_d;
  logic [DW-1:0]       held_q, held_d, word_sel;
  logic                fd_q, fd_d;
  logic [11:0]         h12, v12;
  logic                in_win, frame_start, go, is_last;
  logic [7:0]          lane_pix;
  logic [23:0]         colors_c;
`ifdef VRAM_PAINTER_BORDER_EN
  localparam logic [11:0] HB_LO = (H_START > 0) ? 12'(H_START - 1) : 12'd0;
  localparam logic [11:0] VB_LO = (V_START > 0) ? 12'(V_START - 1) : 12'd0;
  logic ring, s1_border_q, s1_border_d, s2_border_q, s2_border_d;
`endif

  assign h12         = {2'b00, bus.horzCoord};
  assign v12         = {2'b00, bus.vertCoord};
  assign in_win      = (h12 >= H_LO) && (h12 < H_HI) && (v12 >= V_LO) && (v12 < V_HI);
  assign frame_start = (bus.horzCoord == 10'd0) && (bus.vertCoord == 10'd0);
`ifdef VRAM_PAINTER_BORDER_EN
  assign ring = !in_win && (h12 >= HB_LO) && (h12 <= H_HI) && (v12 >= VB_LO) && (v12 <= V_HI);
`endif

  // Frame start acts as if counters were already cleared, so a window touching (0,0) still works.
  always_comb begin
    eff_state = frame_start ? IDLE : state_q;
    armed_eff = armed_q | frame_start;
    lane_cur  = frame_start ? '0 : lane_q;
    word_cur  = frame_start ? '0 : word_q;
    cnt_cur   = frame_start ? '0 : cnt_q;
    go        = in_win && ((eff_state == ACTIVE) || ((eff_state == IDLE) && armed_eff));
    is_last   = (cnt_cur == CNT_W'(NPIX - 1));

    state_d   = eff_state;
    armed_d   = armed_eff;
    lane_d    = lane_cur;
    word_d    = word_cur;
    cnt_d     = cnt_cur;
    rd_d      = 1'b0;
    a_vga_d   = a_vga_q;
    if (go) begin
      armed_d = 1'b0;
      state_d = is_last ? DONE : ACTIVE;
      cnt_d   = cnt_cur + CNT_W'(1);
      rd_d    = (lane_cur == '0);
      if (lane_cur == '0) a_vga_d = word_cur;
      if (lane_cur == LANE_W'(PIX_PER_WORD - 1)) begin
        lane_d = '0;
        word_d = word_cur + ADDR_W'(1);
      end else begin
        lane_d = lane_cur + LANE_W'(1);
      end
    end

    s1_pix_d   = go;
    s1_lane_d  = lane_cur;
    s1_last_d  = go && is_last;
    s2_pix_d   = s1_pix_q;
    s2_lane_d  = s1_lane_q;
    s2_last_d  = s1_last_q;
    s2_fresh_d = rd_q;
    held_d     = s2_fresh_q ? bus.vram_rdata : held_q;
    fd_d       = s2_pix_q && s2_last_q;
`ifdef VRAM_PAINTER_BORDER_EN
    s1_border_d = ring;
    s2_border_d = s1_border_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      lane_q     <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      a_vga_q    <= '0;
      s1_pix_q   <= 1'b0;
      s1_lane_q  <= '0;
      s1_last_q  <= 1'b0;
      s2_pix_q   <= 1'b0;
      s2_lane_q  <= '0;
      s2_last_q  <= 1'b0;
      s2_fresh_q <= 1'b0;
      held_q     <= '0;
      fd_q       <= 1'b0;
`ifdef VRAM_PAINTER_BORDER_EN
      s1_border_q <= 1'b0;
      s2_border_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      a_vga_q    <= a_vga_d;
      s1_pix_q   <= s1_pix_d;
      s1_lane_q  <= s1_lane_d;
      s1_last_q  <= s1_last_d;
      s2_pix_q   <= s2_pix_d;
      s2_lane_q  <= s2_lane_d;
      s2_last_q  <= s2_last_d;
      s2_fresh_q <= s2_fresh_d;
      held_q     <= held_d;
      fd_q       <= fd_d;
`ifdef VRAM_PAINTER_BORDER_EN
      s1_border_q <= s1_border_d;
      s2_border_q <= s2_border_d;
`endif
    end
  end

  // Lane 0 arrives straight from VRAM this cycle; later lanes come from the held word.
  always_comb begin
    word_sel = s2_fresh_q ? bus.vram_rdata : held_q;
    lane_pix = 8'h00;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (s2_lane_q == LANE_W'(i)) lane_pix = word_sel[8*i +: 8];
    end
    colors_c = BG_COLOR;
`ifdef VRAM_PAINTER_BORDER_EN
    if (s2_border_q) colors_c = 24'hFFFFFF;
`endif
    if (s2_pix_q) colors_c = {lane_pix, lane_pix, lane_pix};
  end

  assign bus.rd_en      = rd_q;
  assign bus.a_vga      = a_vga_q;
  assign bus.pixel      = s2_pix_q;
  assign bus.colors     = colors_c;
  assign bus.frame_done = fd_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_vram_painter.sv
// Bench for vram_painter: default-size instance plus a small 10x4 / 4-lane instance fed the same coordinates.
module tb_vram_painter;
  localparam int          HS = 192;
  localparam int          VS = 112;
  localparam logic [23:0] BG = 24'h000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] h_in = 10'd1;
  logic [9:0] v_in = 10'd1;

  vram_painter_if #(.PIX_PER_WORD(6), .ADDR_W(17)) bus_a ();
  vram_painter_if #(.PIX_PER_WORD(4), .ADDR_W(4))  bus_b ();

  vram_painter #(.IMG_W(256), .IMG_H(256), .PIX_PER_WORD(6), .ADDR_W(17))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  vram_painter #(.IMG_W(10), .IMG_H(4), .PIX_PER_WORD(4), .ADDR_W(4))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_a.horzCoord = h_in;
  assign bus_a.vertCoord = v_in;
  assign bus_b.horzCoord = h_in;
  assign bus_b.vertCoord = v_in;

  // clock / reset
  always #5 clk = ~clk;

  int img_w [2] = '{256, 10};
  int img_h [2] = '{256, 4};
  int ppw   [2] = '{6, 4};
  int m_state [2];
  int m_armed [2];
  int m_p     [2];

  logic [51:0] exp_q [$];
  logic [35:0] rd_q  [$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic fd_valid = 1'b0;
  logic fd_exp_a = 1'b0;
  logic fd_exp_b = 1'b0;
  int   rd_cnt_a = 0, rd_cnt_b = 0, fd_cnt_a = 0, fd_cnt_b = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // VRAM content: byte k of word a holds (a*ppw+k+1), so image pixel p reads as (p+1).
  function automatic logic [63:0] mk_word(input int n, input int a);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = 8'(a * n + k + 1);
    return w;
  endfunction

  always @(posedge clk) begin : vram_model
    logic [63:0] junk, wa, wb;
    junk = {$urandom(), $urandom()};
    wa = mk_word(6, int'(bus_a.a_vga));
    wb = mk_word(4, int'(bus_b.a_vga));
    bus_a.vram_rdata <= bus_a.rd_en ? wa[47:0] : junk[47:0];
    bus_b.vram_rdata <= bus_b.rd_en ? wb[31:0] : junk[31:0];
  end

  // Reference behaviour for one coordinate; e = {last, pixel, colors}, r = {rd, addr}.
  task automatic model(input int d, input int h, input int v,
                       output logic [25:0] e, output logic [17:0] r);
    logic       go, last, inwin;
    logic [7:0] c;
    logic [23:0] col;
    int p;
    if (h == 0 && v == 0) begin
      m_p[d] = 0; m_armed[d] = 1; m_state[d] = 0;
    end
    inwin = (h >= HS) && (h < HS + img_w[d]) && (v >= VS) && (v < VS + img_h[d]);
    go    = inwin && (m_state[d] == 1 || (m_state[d] == 0 && m_armed[d] == 1));
    col   = BG;
    last  = 1'b0;
    r     = '0;
`ifdef VRAM_PAINTER_BORDER_EN
    if (!inwin && h >= HS - 1 && h <= HS + img_w[d] && v >= VS - 1 && v <= VS + img_h[d])
      col = 24'hFFFFFF;
`endif
    if (go) begin
      p    = m_p[d];
      c    = 8'(p + 1);
      col  = {c, c, c};
      last = (p == img_w[d] * img_h[d] - 1);
      if (p % ppw[d] == 0) r = {1'b1, 17'(p / ppw[d])};
      m_p[d]     = p + 1;
      m_armed[d] = 0;
      m_state[d] = last ? 2 : 1;
    end
    e = {last, go, col};
  endtask

  // driver
  task automatic drive(input int h, input int v);
    logic [25:0] ea, eb;
    logic [17:0] ra, rb;
    h_in = 10'(h);
    v_in = 10'(v);
    model(0, h, v, ea, ra);
    model(1, h, v, eb, rb);
    exp_q.push_back({ea, eb});
    rd_q.push_back({ra, rb});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    rd_q.delete();
    fd_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0; m_armed[d] = 0; m_p[d] = 0;
    end
    @(posedge clk); @(posedge clk); #1;
    chk("rst_a_pixel",  bus_a.pixel, 0);
    chk("rst_a_colors", bus_a.colors, BG);
    chk("rst_a_rd_en",  bus_a.rd_en, 0);
    chk("rst_a_addr",   bus_a.a_vga, 0);
    chk("rst_a_fd",     bus_a.frame_done, 0);
    chk("rst_a_state",  bus_a.state_dbg, 0);
    chk("rst_b_pixel",  bus_b.pixel, 0);
    chk("rst_b_colors", bus_b.colors, BG);
    chk("rst_b_rd_en",  bus_b.rd_en, 0);
    chk("rst_b_addr",   bus_b.a_vga, 0);
    rst = 1'b0;
  endtask

  // scoreboard: pixel/colors two clk after the coordinate, rd_en one clk after, frame_done three
  always @(negedge clk) begin : scoreboard
    logic [51:0] e;
    logic [35:0] r;
    if (fd_valid) begin
      chk("a_frame_done", bus_a.frame_done, fd_exp_a);
      chk("b_frame_done", bus_b.frame_done, fd_exp_b);
    end
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      chk("a_pixel",  bus_a.pixel,  e[50]);
      chk("a_colors", bus_a.colors, e[49:26]);
      chk("b_pixel",  bus_b.pixel,  e[24]);
      chk("b_colors", bus_b.colors, e[23:0]);
      fd_exp_a = e[51];
      fd_exp_b = e[25];
      fd_valid = 1'b1;
    end else begin
      fd_valid = 1'b0;
    end
    if (rd_q.size() == 2) begin
      r = rd_q.pop_front();
      chk("a_rd_en", bus_a.rd_en, r[35]);
      if (r[35]) chk("a_addr", bus_a.a_vga, r[34:18]);
      chk("b_rd_en", bus_b.rd_en, r[17]);
      if (r[17]) chk("b_addr", bus_b.a_vga, r[16:0]);
    end
    if (bus_a.rd_en)      rd_cnt_a++;
    if (bus_b.rd_en)      rd_cnt_b++;
    if (bus_a.frame_done) fd_cnt_a++;
    if (bus_b.frame_done) fd_cnt_b++;
  end

  initial begin
    @(posedge clk); #1;
    do_reset();

    // first pixels, small-window line wrap, out-of-window and border probes
    drive(0, 0);
    for (int h = 190; h <= 203; h++) drive(h, 112);
    drive(448, 112);
    for (int h = 190; h <= 203; h++) drive(h, 113);
    drive(191, 150);
    idle(4);

    // reset mid-frame: nothing until the next frame start
    drive(300, 200);
    do_reset();
    for (int h = 300; h <= 305; h++) drive(h, 200);
    drive(192, 112);
    idle(3);
    drive(0, 0);
    for (int h = 192; h <= 199; h++) drive(h, 112);
    idle(4);

    // full frame over the window rows, one border column either side
    rd_cnt_a = 0; rd_cnt_b = 0; fd_cnt_a = 0; fd_cnt_b = 0;
    drive(0, 0);
    for (int v = 112; v <= 367; v++)
      for (int h = 191; h <= 448; h++) drive(h, v);
    idle(4);
    chk("a_read_count",   rd_cnt_a, 10923);
    chk("a_last_addr",    bus_a.a_vga, 10922);
    chk("a_frame_done_n", fd_cnt_a, 1);
    chk("b_read_count",   rd_cnt_b, 10);
    chk("b_frame_done_n", fd_cnt_b, 1);

    // DONE ignores the window until the next frame start
    drive(192, 113);
    idle(3);
    drive(0, 0);
    for (int h = 192; h <= 197; h++) drive(h, 112);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
